// File: rtl/exe_ctrl_pkg.sv
// Shared definitions for the EXE issue/hazard controller.
//   - instruction-type codes carried from DEC
//   - forward-select codes driven to the EXE operand muxes
//   - stage_rec_t: the per-stage record kept for E, M and W
package exe_ctrl_pkg;

  // Register index width stored in the stage records; the top-level REG_AW
  // parameter is expected to match it.
  localparam int REC_AW = 4;

  localparam logic [1:0] ITYPE_R  = 2'b00;
  localparam logic [1:0] ITYPE_BR = 2'b01;
  localparam logic [1:0] ITYPE_I  = 2'b10;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic              valid;
    logic [REC_AW-1:0] rd;
    logic              writes_rd;
    logic              is_load;
  } stage_rec_t;

endpackage

// File: rtl/exe_hazard_unit.sv
// Combinational hazard detection for the instruction presented by DEC.
// Ports:
//   dec_valid, dec_rs1, dec_rs2, dec_instr_type : candidate instruction
//   e_rec, m_rec                                : current E and M records
//   fwd_sel_a, fwd_sel_b                        : operand sources to register into E
//   load_use_stall                              : E holds a load that DEC needs now
module exe_hazard_unit
  import exe_ctrl_pkg::*;
(
  input  logic              dec_valid,
  input  logic [REC_AW-1:0] dec_rs1,
  input  logic [REC_AW-1:0] dec_rs2,
  input  logic [1:0]        dec_instr_type,
  input  stage_rec_t        e_rec,
  input  stage_rec_t        m_rec,
  output logic [1:0]        fwd_sel_a,
  output logic [1:0]        fwd_sel_b,
  output logic              load_use_stall
);

  // A producer in E will sit in M when the consumer reaches E, so it maps to
  // FWD_MEM; a producer in M maps to FWD_WB. E is checked first so the
  // younger producer wins. A load in E cannot forward yet: that case stalls.
  function automatic logic [1:0] pick_src(input logic [REC_AW-1:0] src,
                                          input stage_rec_t e,
                                          input stage_rec_t m);
    logic [1:0] sel;
    sel = FWD_RF;
    if (src != '0) begin
      if (e.valid && e.writes_rd && !e.is_load && (src == e.rd))
        sel = FWD_MEM;
      else if (m.valid && m.writes_rd && (src == m.rd))
        sel = FWD_WB;
    end
    return sel;
  endfunction

  logic uses_rs2;
  logic unused_m_is_load;

  assign uses_rs2         = (dec_instr_type != ITYPE_I);
  assign unused_m_is_load = m_rec.is_load;

  assign fwd_sel_a = pick_src(dec_rs1, e_rec, m_rec);
  assign fwd_sel_b = uses_rs2 ? pick_src(dec_rs2, e_rec, m_rec) : FWD_RF;

  assign load_use_stall = dec_valid && e_rec.valid && e_rec.is_load &&
                          (e_rec.rd != '0) &&
                          ((dec_rs1 == e_rec.rd) ||
                           (uses_rs2 && (dec_rs2 == e_rec.rd)));

endmodule

// File: rtl/exe_issue_ctrl.sv
// Issue and hazard controller for the EXE stage.
// Tracks the E/M/W stage records, registers forwarding selects with each
// issued instruction, inserts load-use and taken-branch bubbles, and drives
// the register-file write port from W.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   dec_*                            : decoded instruction and handshake from DEC
//   z_flag                           : branch condition for the instruction in E
//   pipe_hold                        : freeze all stages (memory busy)
//   exe_valid, fwd_sel_a, fwd_sel_b  : E-stage status and operand mux selects
//   flush                            : squash the wrong-path instruction upstream
//   wb_we, wb_rd                     : register-file write enable / address
//   stall_cnt                        : saturating count of load-use bubbles
module exe_issue_ctrl
  import exe_ctrl_pkg::*;
#(
  parameter int REG_AW = REC_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [REG_AW-1:0] dec_rs1,
  input  logic [REG_AW-1:0] dec_rs2,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic [1:0]        dec_instr_type,
  input  logic              dec_is_load,
  input  logic              dec_writes_rd,
  input  logic              z_flag,
  input  logic              pipe_hold,
  output logic              exe_valid,
  output logic [1:0]        fwd_sel_a,
  output logic [1:0]        fwd_sel_b,
  output logic              flush,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_rd,
  output logic [CNT_W-1:0]  stall_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  stage_rec_t       rec_p0, rec_p1, rec_p2;   // E, M, W
  logic [1:0]       type_p0, fwd_a_p0, fwd_b_p0;
  logic [CNT_W-1:0] stall_cnt_q;

  stage_rec_t       issue_rec;
  logic [1:0]       fwd_a_nxt, fwd_b_nxt;
  logic             load_use_stall, branch_taken, accept;
  logic             unused_w_is_load;

  exe_hazard_unit u_hazard (
    .dec_valid      (dec_valid),
    .dec_rs1        (dec_rs1),
    .dec_rs2        (dec_rs2),
    .dec_instr_type (dec_instr_type),
    .e_rec          (rec_p0),
    .m_rec          (rec_p1),
    .fwd_sel_a      (fwd_a_nxt),
    .fwd_sel_b      (fwd_b_nxt),
    .load_use_stall (load_use_stall)
  );

  // z_flag is only meaningful while the stage is advancing; under hold the
  // branch stays in E and resolves after release.
  assign branch_taken = !rst && !pipe_hold && rec_p0.valid &&
                        (type_p0 == ITYPE_BR) && z_flag;
  assign dec_ready    = !rst && !pipe_hold && !load_use_stall && !branch_taken;
  assign accept       = dec_valid && dec_ready;

  always_comb begin
    issue_rec = '0;
    if (accept) begin
      issue_rec.valid     = 1'b1;
      issue_rec.rd        = dec_rd;
      issue_rec.writes_rd = dec_writes_rd;
      issue_rec.is_load   = dec_is_load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rec_p0      <= '0;
      rec_p1      <= '0;
      rec_p2      <= '0;
      type_p0     <= ITYPE_R;
      fwd_a_p0    <= FWD_RF;
      fwd_b_p0    <= FWD_RF;
      stall_cnt_q <= '0;
    end else if (!pipe_hold) begin
      // DEC -> E boundary
      rec_p0   <= issue_rec;
      type_p0  <= accept ? dec_instr_type : ITYPE_R;
      fwd_a_p0 <= accept ? fwd_a_nxt : FWD_RF;
      fwd_b_p0 <= accept ? fwd_b_nxt : FWD_RF;
      // E -> M boundary
      rec_p1   <= rec_p0;
      // M -> W boundary
      rec_p2   <= rec_p1;
      // A flush bubble takes precedence and is not counted as a stall.
      if (load_use_stall && !branch_taken)
        stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  assign unused_w_is_load = rec_p2.is_load;

  assign exe_valid = rec_p0.valid;
  assign fwd_sel_a = fwd_a_p0;
  assign fwd_sel_b = fwd_b_p0;
  assign flush     = branch_taken;
  assign wb_we     = rec_p2.valid && rec_p2.writes_rd && (rec_p2.rd != '0);
  assign wb_rd     = rec_p2.rd;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/exe_issue_ctrl.md
# exe_issue_ctrl

Issue and hazard controller for the EXE stage. It accepts decoded instructions from DEC and tracks the three in-flight stages (E, M, W). It drives the forwarding selects for the EXE operand muxes, inserts load-use bubbles, squashes on taken branches reported by the condition ALU's z_flag, and sequences register-file write enables. It sits between DEC and EXE and owns all pipeline-advance decisions for the back end.

## Interface
Parameters:
- REG_AW, 4, register index width (16 registers)
- CNT_W, 16, width of the stall performance counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- dec_valid  in  1  DEC presents an instruction
- dec_ready  out  1  controller accepts it this cycle
- dec_rs1, dec_rs2, dec_rd  in  REG_AW  register fields
- dec_instr_type  in  2  00 R-type, 01 branch, 10 I-type
- dec_is_load  in  1  instruction is a load (writes rd from memory)
- dec_writes_rd  in  1  instruction writes rd
- z_flag  in  1  condition result from EXE for the instruction in E
- pipe_hold  in  1  memory busy; freeze E/M/W
- exe_valid  out  1  E holds a live instruction
- fwd_sel_a, fwd_sel_b  out  2  operand source for EXE: 00 reg file, 01 M result, 10 W result
- flush  out  1  taken branch; DEC/fetch squash wrong-path instruction
- wb_we  out  1  register-file write enable (W live and writes rd)
- wb_rd  out  REG_AW  register-file write address
- stall_cnt  out  CNT_W  saturating count of load-use bubbles

## Operation
- Stage records E, M and W each hold: valid, rd, writes_rd, is_load. E also holds instr_type and both fwd_sel values.
- r0 is hardwired zero. A source or destination of 0 never matches for forwarding or stall.
- Forwarding is computed at issue against the current E and M records, then registered into E with the instruction.
  - For operand A: if dec_rs1 == E.rd, E.valid, E.writes_rd and !E.is_load, select 01 (the producer will be in M).
  - Else if dec_rs1 == M.rd, M.valid and M.writes_rd, select 10.
  - Else select 00. The younger match wins.
  - Operand B uses the same rule with dec_rs2. It is evaluated only for R-type and branch; for I-type fwd_sel_b = 00.
- Load-use stall: dec_valid and E is a valid load whose rd matches a used source.
  - dec_ready = 0 and a bubble enters E.
  - stall_cnt increments once per bubble and saturates at all-ones.
- Taken branch: E.valid, E.instr_type == 01 and z_flag = 1.
  - flush = 1 and dec_ready = 0 that cycle; a bubble enters E.
  - Flush has priority over the load-use stall; no stall is counted in a flush cycle.
- dec_ready = !rst & !pipe_hold & !stall & !flush.
- Advance occurs when !pipe_hold: W <= M, M <= E, and E <= the accepted instruction or a bubble.
  - With pipe_hold = 1, all records hold, flush is forced to 0 and z_flag is ignored.
- wb_we = W.valid & W.writes_rd & (W.rd != 0); wb_rd = W.rd.
- The register file is write-first, so a producer leaving W is visible to an instruction reading in E the next cycle.

## Timing
- Reset: all valid bits 0. exe_valid, flush, wb_we and dec_ready are 0. fwd_sel_a/b = 00, wb_rd = 0, stall_cnt = 0.
- rst asserted mid-operation discards all in-flight instructions at the next edge. No write enable is issued after that edge.
- Issue at edge N places the instruction in E from N+1 to N+2, with exe_valid and fwd_sel valid at N+1. It is in M at N+2 and in W (wb_we) at N+3. This assumes no hold.
- A load-use dependency costs exactly one bubble. The dependent instruction is then accepted with fwd_sel = 10.
- A taken branch costs one bubble. flush is a single cycle, combinational from E and z_flag.
- Back-to-back dependent ALU operations issue on consecutive cycles with no bubble.
- pipe_hold with dec_valid: the instruction is not consumed. DEC must hold its fields stable.

## Structure
- Shared package exe_ctrl_pkg holds:
  - instruction-type constants: ITYPE_R = 00, ITYPE_BR = 01, ITYPE_I = 10
  - forward-select constants: FWD_RF = 00, FWD_MEM = 01, FWD_WB = 10
  - a stage_rec_t struct (valid, rd, writes_rd, is_load)
- One sub-module, exe_hazard_unit, is natural. It is purely combinational: it takes the DEC fields plus the E and M records, and produces fwd_sel_a/b and load_use_stall. The controller instantiates it and owns all registers and the counter.

## Test plan
- Dependent R-types: ADD r3 <- r1, r2 then SUB r4 <- r3, r5 on consecutive cycles -> the second has fwd_sel_a = 01 and fwd_sel_b = 00, with no bubble. The gapped case gives fwd_sel_a = 10.
- Load-use: LD r6 then ADD r7 <- r6, r6 -> one cycle with dec_ready = 0. E bubble gives exe_valid = 0, stall_cnt becomes 1, then the ADD issues with fwd_sel_a = fwd_sel_b = 10.
- Taken branch with z_flag = 1 in E -> flush = 1 for one cycle and dec_ready = 0. The next E is a bubble, and no wb_we appears for the squashed slot. With z_flag = 0: no flush, and the following instruction issues normally.
- r0 writes: ADD r0 <- … then a consumer of r0 -> fwd_sel = 00, no stall, and wb_we stays 0 at W.
- pipe_hold held for 3 cycles with a load in E and a dependent instruction on DEC -> E/M/W unchanged, flush = 0 and stall_cnt unchanged. After release, a single bubble is inserted.
- Reset mid-stream with three live instructions -> the next cycle shows exe_valid = 0 and wb_we = 0 with all outputs at reset values. Force stall_cnt to 16'hFFFF, then a further load-use stall leaves it at 16'hFFFF.
